enc_8b10b_tx: RTL and testbench

Byte-to-symbol encoder that sits directly upstream of the TX PISO in the SerDes transmit path. Each accepted byte, data or control (K), is encoded to a DC-balanced 10-bit 8b/10b symbol using a running disparity register. The 10-bit symbol is presented on `TxParallel_10` and held stable for exactly 10 `BitCLK` cycles, one full PISO shift. A free-running word counter paces a valid/ready byte handshake to the serializer's word rate.

---
 rtl/enc_8b10b_tx_if.sv | 34 +++
 rtl/enc_8b10b_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_enc_8b10b_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/enc_8b10b_tx_if.sv
// Byte-in / symbol-out bundle between the upstream byte source and the 8b/10b encoder.
// The master drives the byte handshake and the slave (encoder) returns the symbol and status.
interface enc_8b10b_tx_if;
    logic [7:0] TxData_8;
    logic       TxDataK;
    logic       TxValid;
    logic       TxReady;
    logic [9:0] TxParallel_10;
    logic       WordStart;
    logic       RunDisp;
    logic       CodeErr;

    modport master (
        output TxData_8,
        output TxDataK,
        output TxValid,
        input  TxReady,
        input  TxParallel_10,
        input  WordStart,
        input  RunDisp,
        input  CodeErr
    );

    modport slave (
        input  TxData_8,
        input  TxDataK,
        input  TxValid,
        output TxReady,
        output TxParallel_10,
        output WordStart,
        output RunDisp,
        output CodeErr
    );
endinterface

// File: rtl/enc_8b10b_tx.sv
// 8b/10b transmit encoder paced by a 10-cycle word counter, feeding the TX PISO one symbol per word.
// Define ENC_IDLE_COMMA_EN to fill idle word slots with K28.5; otherwise idle slots load 10'h000.
module enc_8b10b_tx (
    input  logic          BitCLK,
    input  logic          Reset,
    enc_8b10b_tx_if.slave tx
);

    logic [3:0] wordCnt_q, wordCnt_d;
    logic [9:0] symbol_q, symbol_d;
    logic       runDisp_q, runDisp_d;
    logic       wordStart_q, wordStart_d;
    logic       codeErr_q, codeErr_d;

    logic       loadSlot;
    logic       kLegal;
    logic [4:0] encX;
    logic [2:0] encY;
    logic       encK;
    logic       badK;

    logic [5:0] code6;
    logic [3:0] ones6;
    logic       unbal6;
    logic       compl6;
    logic [5:0] sixB;
    logic       rdMid;

    logic       useA7;
    logic [3:0] code4;
    logic [3:0] ones4;
    logic       unbal4;
    logic       compl4;
    logic [3:0] fourB;

    logic [9:0]        encSym;
    logic signed [4:0] symDisp;
    logic              encRd;

    function automatic logic [3:0] onesCount(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign loadSlot = (wordCnt_q == 4'd9);

    assign kLegal = (tx.TxData_8[4:0] == 5'd28) ||
                    ((tx.TxData_8[7:5] == 3'd7) &&
                     ((tx.TxData_8[4:0] == 5'd23) || (tx.TxData_8[4:0] == 5'd27) ||
                      (tx.TxData_8[4:0] == 5'd29) || (tx.TxData_8[4:0] == 5'd30)));

    // Illegal K requests and idle slots both collapse onto K28.5 at the current disparity.
    always_comb begin
        encX = tx.TxData_8[4:0];
        encY = tx.TxData_8[7:5];
        encK = tx.TxDataK;
        badK = 1'b0;
        if (!tx.TxValid) begin
            encX = 5'd28;
            encY = 3'd5;
            encK = 1'b1;
        end else if (tx.TxDataK && !kLegal) begin
            encX = 5'd28;
            encY = 3'd5;
            encK = 1'b1;
            badK = 1'b1;
        end
    end

    // 5b/6b table, stored in the RD- form; RD+ uses the complement where the code is not self-balanced.
    always_comb begin
        code6 = 6'b000000;
        unique case (encX)
            5'd0:  code6 = 6'b100111;
            5'd1:  code6 = 6'b011101;
            5'd2:  code6 = 6'b101101;
            5'd3:  code6 = 6'b110001;
            5'd4:  code6 = 6'b110101;
            5'd5:  code6 = 6'b101001;
            5'd6:  code6 = 6'b011001;
            5'd7:  code6 = 6'b111000;
            5'd8:  code6 = 6'b111001;
            5'd9:  code6 = 6'b100101;
            5'd10: code6 = 6'b010101;
            5'd11: code6 = 6'b110100;
            5'd12: code6 = 6'b001101;
            5'd13: code6 = 6'b101100;
            5'd14: code6 = 6'b011100;
            5'd15: code6 = 6'b010111;
            5'd16: code6 = 6'b011011;
            5'd17: code6 = 6'b100011;
            5'd18: code6 = 6'b010011;
            5'd19: code6 = 6'b110010;
            5'd20: code6 = 6'b001011;
            5'd21: code6 = 6'b101010;
            5'd22: code6 = 6'b011010;
            5'd23: code6 = 6'b111010;
            5'd24: code6 = 6'b110011;
            5'd25: code6 = 6'b100110;
            5'd26: code6 = 6'b010110;
            5'd27: code6 = 6'b110110;
            5'd28: code6 = encK ? 6'b001111 : 6'b001110;
            5'd29: code6 = 6'b101110;
            5'd30: code6 = 6'b011110;
            5'd31: code6 = 6'b101011;
            default: code6 = 6'b000000;
        endcase
    end

    assign ones6  = onesCount({4'b0000, code6});
    assign unbal6 = (ones6 != 4'd3);
    assign compl6 = unbal6 || (encX == 5'd7);
    assign sixB   = (runDisp_q && compl6) ? ~code6 : code6;
    assign rdMid  = runDisp_q ^ unbal6;

    // A7 replaces P7 where P7 would create a run of five identical bits across the sub-block boundary.
    assign useA7 = !encK && (encY == 3'd7) &&
                   ((!rdMid && ((encX == 5'd17) || (encX == 5'd18) || (encX == 5'd20))) ||
                    ( rdMid && ((encX == 5'd11) || (encX == 5'd13) || (encX == 5'd14))));

    // 3b/4b table in the form used when the disparity after the 6b sub-block is RD-.
    always_comb begin
        code4 = 4'b0000;
        if (encK) begin
            unique case (encY)
                3'd0: code4 = 4'b1011;
                3'd1: code4 = 4'b0110;
                3'd2: code4 = 4'b1010;
                3'd3: code4 = 4'b1100;
                3'd4: code4 = 4'b1101;
                3'd5: code4 = 4'b0101;
                3'd6: code4 = 4'b1001;
                3'd7: code4 = 4'b0111;
                default: code4 = 4'b0000;
            endcase
        end else begin
            unique case (encY)
                3'd0: code4 = 4'b1011;
                3'd1: code4 = 4'b1001;
                3'd2: code4 = 4'b0101;
                3'd3: code4 = 4'b1100;
                3'd4: code4 = 4'b1101;
                3'd5: code4 = 4'b1010;
                3'd6: code4 = 4'b0110;
                3'd7: code4 = useA7 ? 4'b0111 : 4'b1110;
                default: code4 = 4'b0000;
            endcase
        end
    end

    assign ones4  = onesCount({6'b000000, code4});
    assign unbal4 = (ones4 != 4'd2);
    assign compl4 = unbal4 || (encY == 3'd3) || encK;
    assign fourB  = (rdMid && compl4) ? ~code4 : code4;

    assign encSym  = {sixB, fourB};
    assign symDisp = $signed({1'b0, onesCount(encSym)}) - 5'sd5;

    // A neutral symbol keeps the running disparity; an unbalanced one sets it to its own sign.
    always_comb begin
        encRd = runDisp_q;
        if (symDisp != 5'sd0) begin
            encRd = (symDisp > 5'sd0);
        end
    end

    // Word counter and symbol register update; loads happen only on the edge that ends count 9.
    always_comb begin
        wordCnt_d   = loadSlot ? 4'd0 : wordCnt_q + 4'd1;
        symbol_d    = symbol_q;
        runDisp_d   = runDisp_q;
        wordStart_d = 1'b0;
        codeErr_d   = codeErr_q;
        if (loadSlot) begin
            if (tx.TxValid) begin
                symbol_d    = encSym;
                runDisp_d   = encRd;
                wordStart_d = 1'b1;
                codeErr_d   = badK;
            end else begin
`ifdef ENC_IDLE_COMMA_EN
                symbol_d    = encSym;
                runDisp_d   = encRd;
                wordStart_d = 1'b1;
                codeErr_d   = 1'b0;
`else
                symbol_d    = 10'h000;
                codeErr_d   = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            wordCnt_q   <= 4'd0;
            symbol_q    <= 10'h000;
            runDisp_q   <= 1'b0;
            wordStart_q <= 1'b0;
            codeErr_q   <= 1'b0;
        end else begin
            wordCnt_q   <= wordCnt_d;
            symbol_q    <= symbol_d;
            runDisp_q   <= runDisp_d;
            wordStart_q <= wordStart_d;
            codeErr_q   <= codeErr_d;
        end
    end

    assign tx.TxReady       = loadSlot;
    assign tx.TxParallel_10 = symbol_q;
    assign tx.WordStart     = wordStart_q;
    assign tx.RunDisp       = runDisp_q;
    assign tx.CodeErr       = codeErr_q;

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// Scoreboard bench for enc_8b10b_tx: the driver queues hand-computed symbols, the monitor checks
// every cycle against its own word timing (works with or without ENC_IDLE_COMMA_EN).
module tb_enc_8b10b_tx;

    typedef struct packed {
        logic       ws;
        logic [9:0] sym;
        logic       rd;
        logic       err;
    } exp_t;

    logic BitCLK = 1'b0;
    logic Reset  = 1'b1;

    enc_8b10b_tx_if txIf ();

    enc_8b10b_tx dut (
        .BitCLK (BitCLK),
        .Reset  (Reset),
        .tx     (txIf)
    );

    always #5 BitCLK = ~BitCLK;

    exp_t       expQ[$];
    exp_t       mon;
    int         checks = 0;
    int         fails  = 0;
    int         expCnt = 0;
    logic       loadEdge  = 1'b0;
    logic       resetSeen = 1'b0;
    logic       armed     = 1'b0;
    logic [9:0] heldSym = 10'h000;
    logic       heldRd  = 1'b0;
    logic       heldErr = 1'b0;

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%03h, expected 0x%03h", name, $time, act, exp);
        end
    endtask

    // Reference word timing, independent of the DUT's counter.
    always @(posedge BitCLK) begin
        loadEdge  <= !Reset && (expCnt == 9);
        resetSeen <= Reset;
        armed     <= 1'b1;
        expCnt    <= Reset ? 0 : ((expCnt == 9) ? 0 : expCnt + 1);
    end

    always @(negedge BitCLK) begin
        if (armed) begin
            if (resetSeen) begin
                checkOutput("rst_TxParallel_10", txIf.TxParallel_10, 10'h000);
                checkOutput("rst_RunDisp", {9'b0, txIf.RunDisp}, 10'h000);
                checkOutput("rst_WordStart", {9'b0, txIf.WordStart}, 10'h000);
                checkOutput("rst_CodeErr", {9'b0, txIf.CodeErr}, 10'h000);
                checkOutput("rst_TxReady", {9'b0, txIf.TxReady}, 10'h000);
                heldSym <= 10'h000;
                heldRd  <= 1'b0;
                heldErr <= 1'b0;
            end else if (loadEdge) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got a load edge, expected none", $time);
                end else begin
                    mon = expQ.pop_front();
                    checkOutput("load_WordStart", {9'b0, txIf.WordStart}, {9'b0, mon.ws});
                    checkOutput("load_TxParallel_10", txIf.TxParallel_10, mon.sym);
                    checkOutput("load_RunDisp", {9'b0, txIf.RunDisp}, {9'b0, mon.rd});
                    checkOutput("load_CodeErr", {9'b0, txIf.CodeErr}, {9'b0, mon.err});
                    checkOutput("load_TxReady", {9'b0, txIf.TxReady}, 10'h000);
                    heldSym <= mon.sym;
                    heldRd  <= mon.rd;
                    heldErr <= mon.err;
                end
            end else begin
                checkOutput("hold_WordStart", {9'b0, txIf.WordStart}, 10'h000);
                checkOutput("hold_TxParallel_10", txIf.TxParallel_10, heldSym);
                checkOutput("hold_RunDisp", {9'b0, txIf.RunDisp}, {9'b0, heldRd});
                checkOutput("hold_CodeErr", {9'b0, txIf.CodeErr}, {9'b0, heldErr});
                checkOutput("hold_TxReady", {9'b0, txIf.TxReady}, {9'b0, (expCnt == 9)});
            end
        end
    end

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic k,
                                 input logic ws, input logic [9:0] sym, input logic rd,
                                 input logic err);
        int   guard;
        exp_t e;
        guard = 0;
        txIf.TxValid  = valid;
        txIf.TxData_8 = data;
        txIf.TxDataK  = k;
        while (expCnt != 9 && guard < 20) begin
            @(negedge BitCLK);
            guard++;
        end
        if (expCnt != 9) begin
            checks++;
            fails++;
            $display("[TB] FAIL handshake_timeout at %0t: got no ready slot, expected one within 20 cycles", $time);
        end else begin
            e.ws  = ws;
            e.sym = sym;
            e.rd  = rd;
            e.err = err;
            expQ.push_back(e);
        end
        @(posedge BitCLK);
        #1;
    endtask

    task automatic waitForCount(input int target);
        int guard;
        guard = 0;
        while (expCnt != target && guard < 20) begin
            @(negedge BitCLK);
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog at %0t: got no end of test, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txIf.TxValid  = 1'b0;
        txIf.TxData_8 = 8'h00;
        txIf.TxDataK  = 1'b0;
        repeat (3) @(posedge BitCLK);
        #1;
        Reset = 1'b0;

        // Two idle slots straight after reset.
`ifdef ENC_IDLE_COMMA_EN
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 10'h0FA, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 10'h305, 1'b0, 1'b0);
`else
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
`endif

        // Back-to-back bytes with TxValid held high; RD threads through the sequence.
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 10'h274, 1'b0, 1'b0); // D0.0  RD-
        applyStimulus(1'b1, 8'hB5, 1'b0, 1'b1, 10'h2AA, 1'b0, 1'b0); // D21.5 RD-
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b1, 10'h237, 1'b1, 1'b0); // D17.7 RD- A7
        applyStimulus(1'b1, 8'hEB, 1'b0, 1'b1, 10'h348, 1'b0, 1'b0); // D11.7 RD+ A7
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 10'h0FA, 1'b1, 1'b1); // K0.0 illegal
        applyStimulus(1'b1, 8'hBC, 1'b1, 1'b1, 10'h305, 1'b0, 1'b0); // K28.5 RD+
        applyStimulus(1'b1, 8'h67, 1'b0, 1'b1, 10'h38C, 1'b0, 1'b0); // D7.3  RD-
        applyStimulus(1'b1, 8'hF7, 1'b1, 1'b1, 10'h3A8, 1'b0, 1'b0); // K23.7 RD-
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 10'h2B1, 1'b0, 1'b0); // D31.7 RD- P7
        applyStimulus(1'b1, 8'hF4, 1'b0, 1'b1, 10'h0B7, 1'b1, 1'b0); // D20.7 RD- A7
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 10'h18B, 1'b1, 1'b0); // D0.0  RD+
        applyStimulus(1'b1, 8'h1C, 1'b1, 1'b1, 10'h30B, 1'b1, 1'b0); // K28.0 RD+
        applyStimulus(1'b1, 8'h1E, 1'b1, 1'b1, 10'h305, 1'b0, 1'b1); // K30.0 illegal RD+
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b1, 10'h31B, 1'b1, 1'b0); // D3.0  RD-
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, 10'h074, 1'b0, 1'b0); // D7.0  RD+

        // Reset on the handshake edge: the byte must be dropped.
        txIf.TxValid  = 1'b1;
        txIf.TxData_8 = 8'hF1;
        txIf.TxDataK  = 1'b0;
        waitForCount(9);
        Reset = 1'b1;
        @(posedge BitCLK);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 10'h274, 1'b0, 1'b0); // D0.0  RD-
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 10'h0FA, 1'b1, 1'b1); // K0.0 illegal

        // Reset mid-word clears RD and CodeErr; next load lands 10 edges after release.
        waitForCount(5);
        Reset = 1'b1;
        @(posedge BitCLK);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b1, 10'h237, 1'b1, 1'b0); // D17.7 RD-

        repeat (2) @(negedge BitCLK);
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
